ps2_host_cmd_ctrl: RTL and testbench
====================================

Name: ps2_host_cmd_ctrl

Overview:
- Host-side command sequencer for the PS/2 keyboard port.
- Sits between the system (LED-update and keyboard-reset requesters) and the ps2_tx / ps2_rx byte engines.
- Arbitrates the two requesters and drives the byte sequence (0xED+LED byte, or 0xFF). Checks the keyboard's 0xFA/0xFE/0xAA replies with retry and timeout.
- Reports completion or error to the requester.

Parameters:
- ACK_TIMEOUT, 2000000, cycles to wait for ACK after a byte is sent (20 ms at 100 MHz).
- BAT_TIMEOUT, 100000000, cycles to wait for BAT result after reset ACK (1 s).
- MAX_RETRY, 3, resends allowed per byte on 0xFE before error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- led_req  in  1  level; request LED update, held until done/err
- led_state  in  3  {caps,num,scroll}; sampled on grant
- kbd_rst_req  in  1  level; request keyboard reset, held until done/err
- tx_req  out  1  to ps2_tx; held high until tx_sent
- tx_data  out  8  byte to send; stable while tx_req high
- tx_sent  in  1  one-cycle pulse from ps2_tx; byte fully transmitted
- rx_valid  in  1  one-cycle pulse from ps2_rx
- rx_data  in  8  received byte, valid with rx_valid
- busy  out  1  high from grant until done/err pulse
- done  out  1  one-cycle pulse; command completed OK
- err  out  1  one-cycle pulse; command failed
- err_code  out  2  0=none, 1=ack timeout, 2=retries exhausted, 3=BAT fail/timeout; held until next grant

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_req=0, tx_data=0x00, busy=0, done=0, err=0, err_code=0, retry counter=0, timer=0.
- Reset mid-command: abort immediately; no done/err pulse.
- IDLE, arbitration on the cycle requests are evaluated:
  - kbd_rst_req has priority over led_req. On simultaneous requests the reset is served first; led_req stays pending.
  - Grant: busy=1 and err_code cleared next cycle. led_state is latched into an internal register at grant.
  - Reset grant → SEND (byte=0xFF, kind=RST). LED grant → SEND (byte=0xED, kind=LED1).
- SEND:
  - tx_req=1 with tx_data=current byte.
  - On tx_sent: tx_req=0 next cycle, timer cleared → WAIT_ACK.
  - No timeout in SEND; ps2_tx owns line timing.
- WAIT_ACK (timer increments every cycle):
  - rx 0xFA, kind LED1 → SEND (byte={5'b0,led_latched}, kind=LED2), retry=0.
  - rx 0xFA, kind LED2 → FINISH_OK.
  - rx 0xFA, kind RST → WAIT_BAT, timer cleared.
  - rx 0xFE: if retry<MAX_RETRY, retry+1 → SEND same byte; else FINISH_ERR, err_code=2.
  - Any other byte (stray scan code) ignored; timer not reset.
  - Timer reaches ACK_TIMEOUT-1 with no ACK → FINISH_ERR, err_code=1.
  - rx_valid and timeout on the same cycle: the received byte wins.
- WAIT_BAT:
  - rx 0xAA → FINISH_OK.
  - rx 0xFC → FINISH_ERR, err_code=3.
  - Other bytes ignored.
  - Timeout at BAT_TIMEOUT-1 → FINISH_ERR, err_code=3.
- FINISH_OK: done=1 for one cycle, busy=0 → IDLE.
- FINISH_ERR: err=1 for one cycle, busy=0 → IDLE.
- Requests are sampled again the cycle after returning to IDLE, so a still-high request is re-granted. Requesters must drop their request on done/err.
- Request deasserted mid-command: ignored; the sequence runs to completion.
- Timer width: clog2(BAT_TIMEOUT)+1 bits, saturating; it never wraps.
- Retry counter resets per byte (on each new byte, not on a resend).
- Latency: grant→tx_req high = 1 cycle. Final rx_valid→done/err pulse = 1 cycle.

Decomposition:
- Shared package ps2_pkg:
  - command constants CMD_SET_LED=0xED, CMD_RESET=0xFF
  - reply constants RSP_ACK=0xFA, RSP_RESEND=0xFE, RSP_BAT_OK=0xAA, RSP_BAT_FAIL=0xFC
  - state enum
  - err_code encodings
- Natural sub-module: ps2_reply_timer (loadable saturating counter with two compare thresholds, clear, expire flags).
- FSM and arbitration stay in the top.

Test Plan (ACK_TIMEOUT=100, BAT_TIMEOUT=500, MAX_RETRY=3; bench models ps2_tx/ps2_rx):
- LED update: led_state=3'b101, led_req=1; bench returns tx_sent, 0xFA, tx_sent, 0xFA → tx_data sequence 0xED then 0x05; one done pulse; err_code=0; busy low after done.
- Resend path: LED request; bench replies 0xFE twice, then 0xFA to 0xED, then 0xFA to 0x05 → 0xED sent three times, then 0x05; done pulse. Reply 0xFE four times instead → err pulse, err_code=2.
- Ack timeout: LED request; tx_sent, no reply → err pulse exactly 100 cycles after tx_sent; err_code=1; tx_req=0.
- Keyboard reset: kbd_rst_req=1; bench returns tx_sent, 0xFA, scan code 0x1C, then 0xAA → tx_data=0xFF once; 0x1C ignored; done pulse. Repeat with 0xFC → err_code=3. Repeat with no BAT → err_code=3 after 500 cycles.
- Simultaneous requests: led_req and kbd_rst_req rise on the same cycle → 0xFF sequence first; after its done and reset request dropped, the LED sequence runs with led_state latched at its own grant.
- Async reset mid-WAIT_ACK: pull rst_n low → tx_req, busy, done, err all 0 immediately; no pulse; after release with no requests, stays IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and enumerations for the PS/2 host command controller:
// command/reply bytes, controller states, command kinds and error codes.
package ps2_pkg;

    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_FINISH_OK,
        ST_FINISH_ERR
    } ctrl_state_e;

    // LED1 = 0xED command byte, LED2 = LED bitmap byte, RST = 0xFF reset byte.
    typedef enum logic [1:0] {
        KIND_LED1,
        KIND_LED2,
        KIND_RST
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_ACK_TIMEOUT = 2'd1,
        ERR_RETRY       = 2'd2,
        ERR_BAT         = 2'd3
    } err_code_e;

endpackage

// File: rtl/ps2_host_cmd_ctrl_if.sv
// Bundle of requester, ps2_tx and ps2_rx signals seen by the command controller.
// Handshakes: requests are levels held until done/err; tx_req is held until the
// one-cycle tx_sent pulse; rx_data is only meaningful in the cycle rx_valid is high.
interface ps2_host_cmd_ctrl_if;
    import ps2_pkg::*;

    logic        led_req;
    logic [2:0]  led_state;
    logic        kbd_rst_req;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_sent;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    ctrl_state_e fsm_state;

    // Requesters and byte engines.
    modport master (
        output led_req, led_state, kbd_rst_req, tx_sent, rx_valid, rx_data,
        input  tx_req, tx_data, busy, done, err, err_code, fsm_state
    );

    // The command controller.
    modport slave (
        input  led_req, led_state, kbd_rst_req, tx_sent, rx_valid, rx_data,
        output tx_req, tx_data, busy, done, err, err_code, fsm_state
    );

endinterface

// File: rtl/ps2_reply_timer.sv
// Saturating reply timer with synchronous clear and two expiry compares
// (ACK window and BAT window); counts only while enabled.
module ps2_reply_timer #(
    parameter int unsigned ACK_TIMEOUT = 2000000,
    parameter int unsigned BAT_TIMEOUT = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic ack_expire,
    output logic bat_expire
);

    localparam int unsigned W = $clog2(BAT_TIMEOUT) + 1;
    localparam logic [W-1:0] ACK_LAST = W'(ACK_TIMEOUT - 1);
    localparam logic [W-1:0] BAT_LAST = W'(BAT_TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ack_expire = (cnt == ACK_LAST);
    assign bat_expire = (cnt == BAT_LAST);

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// Host-side PS/2 command sequencer: arbitrates LED-update and keyboard-reset
// requests, sends the byte sequence and checks ACK/RESEND/BAT replies.
module ps2_host_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 2000000,
    parameter int unsigned BAT_TIMEOUT = 100000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    ps2_host_cmd_ctrl_if.slave  bus
);

    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    ctrl_state_e   state;
    cmd_kind_e     kind;
    logic [RW-1:0] retry;
    logic [2:0]    led_latched;

    logic tmr_en;
    logic tmr_clr;
    logic ack_expire;
    logic bat_expire;
    logic rx_ack;
    logic rx_resend;

    assign rx_ack    = bus.rx_valid && (bus.rx_data == RSP_ACK);
    assign rx_resend = bus.rx_valid && (bus.rx_data == RSP_RESEND);

    // Timer is held at zero outside the wait states, so each wait starts from 0;
    // the reset ACK also restarts it for the longer BAT window.
    assign tmr_en  = (state == ST_WAIT_ACK) || (state == ST_WAIT_BAT);
    assign tmr_clr = !tmr_en || ((state == ST_WAIT_ACK) && rx_ack && (kind == KIND_RST));

    ps2_reply_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .BAT_TIMEOUT (BAT_TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (tmr_clr),
        .en         (tmr_en),
        .ack_expire (ack_expire),
        .bat_expire (bat_expire)
    );

    assign bus.fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            kind         <= KIND_LED1;
            retry        <= '0;
            led_latched  <= 3'b000;
            bus.tx_req   <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= ERR_NONE;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.kbd_rst_req) begin
                        state        <= ST_SEND;
                        kind         <= KIND_RST;
                        retry        <= '0;
                        bus.tx_req   <= 1'b1;
                        bus.tx_data  <= CMD_RESET;
                        bus.busy     <= 1'b1;
                        bus.err_code <= ERR_NONE;
                    end else if (bus.led_req) begin
                        state        <= ST_SEND;
                        kind         <= KIND_LED1;
                        retry        <= '0;
                        led_latched  <= bus.led_state;
                        bus.tx_req   <= 1'b1;
                        bus.tx_data  <= CMD_SET_LED;
                        bus.busy     <= 1'b1;
                        bus.err_code <= ERR_NONE;
                    end
                end

                ST_SEND: begin
                    if (bus.tx_sent) begin
                        bus.tx_req <= 1'b0;
                        state      <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    // A recognised reply takes precedence over a same-cycle timeout.
                    if (rx_ack) begin
                        case (kind)
                            KIND_LED1: begin
                                state       <= ST_SEND;
                                kind        <= KIND_LED2;
                                retry       <= '0;
                                bus.tx_req  <= 1'b1;
                                bus.tx_data <= {5'b00000, led_latched};
                            end
                            KIND_LED2: begin
                                state    <= ST_FINISH_OK;
                                bus.done <= 1'b1;
                                bus.busy <= 1'b0;
                            end
                            default: begin
                                state <= ST_WAIT_BAT;
                            end
                        endcase
                    end else if (rx_resend) begin
                        if (retry < RETRY_LIMIT) begin
                            retry      <= retry + 1'b1;
                            bus.tx_req <= 1'b1;
                            state      <= ST_SEND;
                        end else begin
                            state        <= ST_FINISH_ERR;
                            bus.err      <= 1'b1;
                            bus.busy     <= 1'b0;
                            bus.err_code <= ERR_RETRY;
                        end
                    end else if (ack_expire) begin
                        state        <= ST_FINISH_ERR;
                        bus.err      <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.err_code <= ERR_ACK_TIMEOUT;
                    end
                end

                ST_WAIT_BAT: begin
                    if (bus.rx_valid && bus.rx_data == RSP_BAT_OK) begin
                        state    <= ST_FINISH_OK;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else if ((bus.rx_valid && bus.rx_data == RSP_BAT_FAIL) || bat_expire) begin
                        state        <= ST_FINISH_ERR;
                        bus.err      <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.err_code <= ERR_BAT;
                    end
                end

                ST_FINISH_OK,
                ST_FINISH_ERR: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Directed bench for ps2_host_cmd_ctrl: the bench plays ps2_tx/ps2_rx and the
// requesters, replaying per-command event tables and a few hand sequences.
module tb_ps2_host_cmd_ctrl;
  import ps2_pkg::*;

  localparam int unsigned ACK_T = 100;
  localparam int unsigned BAT_T = 500;
  localparam int unsigned MAX_R = 3;
  localparam int N_VEC = 10;
  localparam int N_EV  = 12;
  localparam logic [8:0] TX = 9'h100;

  typedef struct packed {
    logic        rst;
    logic        led;
    logic [2:0]  leds;
    logic        exp_done;
    logic [1:0]  exp_code;
    logic [15:0] exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  ps2_host_cmd_ctrl_if bus();

  ps2_host_cmd_ctrl #(
    .ACK_TIMEOUT (ACK_T),
    .BAT_TIMEOUT (BAT_T),
    .MAX_RETRY   (MAX_R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int mark = 0;

  vec_t vecs[N_VEC];
  logic [8:0] v_ev[N_VEC][N_EV];
  int v_n[N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int i, input logic rst, input logic led, input logic [2:0] leds,
                         input logic exp_done, input logic [1:0] exp_code, input int exp_lat);
    vecs[i] = '{rst: rst, led: led, leds: leds, exp_done: exp_done,
                exp_code: exp_code, exp_lat: 16'(exp_lat)};
    v_n[i] = 0;
  endtask

  task automatic add_ev(input int i, input logic [8:0] ev);
    v_ev[i][v_n[i]] = ev;
    v_n[i]++;
  endtask

  // driver: act as ps2_tx for one byte; mark = cycle of the edge that sampled tx_sent
  task automatic do_tx();
    logic [7:0] exp_b;
    for (int k = 0; k < 50 && !bus.tx_req; k++) @(negedge clk);
    check("tx_req_rise", 32'(bus.tx_req), 32'd1);
    exp_b = exp_q.pop_front();
    check("tx_data", 32'(bus.tx_data), 32'(exp_b));
    bus.tx_sent = 1'b1;
    @(negedge clk);
    bus.tx_sent = 1'b0;
    mark = cyc;
    check("tx_req_drop", 32'(bus.tx_req), 32'd0);
  endtask

  // driver: act as ps2_rx for one byte; mark = cycle of the edge that sampled rx_valid
  task automatic do_rx(input logic [7:0] b);
    repeat (2) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    mark = cyc;
  endtask

  // exp_lat counts clock edges after the marked sampling edge until the pulse is
  // visible; 0 means the pulse is in the cycle right after the final reply.
  task automatic await_finish(input int i);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if (bus.done || bus.err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("finish_seen", 32'(seen), 32'd1);
    check("done", 32'(bus.done), 32'(vecs[i].exp_done));
    check("err", 32'(bus.err), 32'(!vecs[i].exp_done));
    check("err_code", 32'(bus.err_code), 32'(vecs[i].exp_code));
    check("finish_latency", 32'(cyc - mark), 32'(vecs[i].exp_lat));
    check("busy_at_pulse", 32'(bus.busy), 32'd0);
    check("tx_req_at_pulse", 32'(bus.tx_req), 32'd0);
    if (vecs[i].rst) bus.kbd_rst_req = 1'b0;
    else bus.led_req = 1'b0;
    @(negedge clk);
    check("pulse_width", 32'(bus.done | bus.err), 32'd0);
    if (!bus.led_req && !bus.kbd_rst_req) begin
      repeat (3) @(negedge clk);
      check("idle_after", 32'({bus.busy, bus.tx_req}), 32'd0);
      check("err_code_held", 32'(bus.err_code), 32'(vecs[i].exp_code));
    end
  endtask

  task automatic run_vec(input int i);
    logic first;
    first = 1'b1;
    bus.led_state = vecs[i].leds;
    if (vecs[i].rst) bus.kbd_rst_req = 1'b1;
    if (vecs[i].led) bus.led_req = 1'b1;
    for (int e = 0; e < v_n[i]; e++) begin
      if (v_ev[i][e][8]) begin
        exp_q.push_back(v_ev[i][e][7:0]);
        do_tx();
        if (first) begin
          check("busy_during", 32'(bus.busy), 32'd1);
          bus.led_state = ~vecs[i].leds;
          first = 1'b0;
        end
      end else begin
        do_rx(v_ev[i][e][7:0]);
      end
    end
    await_finish(i);
  endtask

  initial begin
    logic any_activity;
    bus.led_req = 1'b0;
    bus.led_state = 3'b000;
    bus.kbd_rst_req = 1'b0;
    bus.tx_sent = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;

    // vector table
    set_vec(0, 1'b0, 1'b1, 3'b101, 1'b1, 2'd0, 0);
    add_ev(0, TX | 9'hED); add_ev(0, 9'hFA); add_ev(0, TX | 9'h05); add_ev(0, 9'hFA);

    set_vec(1, 1'b0, 1'b1, 3'b011, 1'b1, 2'd0, 0);
    add_ev(1, TX | 9'hED); add_ev(1, 9'hFE); add_ev(1, TX | 9'hED); add_ev(1, 9'hFE);
    add_ev(1, TX | 9'hED); add_ev(1, 9'hFA); add_ev(1, TX | 9'h03); add_ev(1, 9'hFA);

    set_vec(2, 1'b0, 1'b1, 3'b000, 1'b0, 2'd2, 0);
    for (int k = 0; k < 4; k++) begin
      add_ev(2, TX | 9'hED); add_ev(2, 9'hFE);
    end

    set_vec(3, 1'b0, 1'b1, 3'b110, 1'b0, 2'd1, 100);
    add_ev(3, TX | 9'hED);

    set_vec(4, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0, 0);
    add_ev(4, TX | 9'hFF); add_ev(4, 9'hFA); add_ev(4, 9'h1C); add_ev(4, 9'hAA);

    set_vec(5, 1'b1, 1'b0, 3'b000, 1'b0, 2'd3, 0);
    add_ev(5, TX | 9'hFF); add_ev(5, 9'hFA); add_ev(5, 9'hFC);

    set_vec(6, 1'b1, 1'b0, 3'b000, 1'b0, 2'd3, 500);
    add_ev(6, TX | 9'hFF); add_ev(6, 9'hFA);

    // retry budget restarts for the second byte
    set_vec(7, 1'b0, 1'b1, 3'b111, 1'b1, 2'd0, 0);
    for (int k = 0; k < 3; k++) begin
      add_ev(7, TX | 9'hED); add_ev(7, 9'hFE);
    end
    add_ev(7, TX | 9'hED); add_ev(7, 9'hFA);
    add_ev(7, TX | 9'h07); add_ev(7, 9'hFE); add_ev(7, TX | 9'h07); add_ev(7, 9'hFA);

    // simultaneous requests: reset first, then LED with its own latched state
    set_vec(8, 1'b1, 1'b1, 3'b010, 1'b1, 2'd0, 0);
    add_ev(8, TX | 9'hFF); add_ev(8, 9'hFA); add_ev(8, 9'hAA);
    set_vec(9, 1'b0, 1'b1, 3'b100, 1'b1, 2'd0, 0);
    add_ev(9, TX | 9'hED); add_ev(9, 9'hFA); add_ev(9, TX | 9'h04); add_ev(9, 9'hFA);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_tx_req", 32'(bus.tx_req), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_state", 32'(bus.fsm_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < N_VEC; i++) run_vec(i);

    // async reset while waiting for ACK
    bus.led_state = 3'b110;
    bus.led_req = 1'b1;
    exp_q.push_back(8'hED);
    do_tx();
    repeat (3) @(negedge clk);
    check("wait_ack_state", 32'(bus.fsm_state), 32'(ST_WAIT_ACK));
    check("wait_ack_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx_req", 32'(bus.tx_req), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done_err", 32'({bus.done, bus.err}), 32'd0);
    check("arst_state", 32'(bus.fsm_state), 32'(ST_IDLE));
    bus.led_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_activity = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      any_activity = any_activity | bus.done | bus.err | bus.busy | bus.tx_req;
    end
    check("arst_quiet", 32'(any_activity), 32'd0);
    check("arst_idle", 32'(bus.fsm_state), 32'(ST_IDLE));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
